// File: rtl/stopwatch_pkg.sv
// Shared state codes, button indices and default timing constants for the stopwatch controller.
// Pure declarations: no logic, no latency.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_READY = 3'd1,
      ST_RUN   = 3'd2,
      ST_LAP   = 3'd3,
      ST_DONE  = 3'd4
   } sw_state_e;

   localparam int TICK_DIV_DEF        = 5_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

   localparam int NUM_BTN     = 5;
   localparam int BTN_INICIAR = 0;
   localparam int BTN_RESET   = 1;
   localparam int BTN_CONTAR  = 2;
   localparam int BTN_PAUSAR  = 3;
   localparam int BTN_PARAR   = 4;

   // Keep only the highest-priority press: Parar > Reset > Contar > Pausar > Iniciar.
   function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] p);
      prio_pick = '0;
      if (p[BTN_PARAR])        prio_pick[BTN_PARAR]   = 1'b1;
      else if (p[BTN_RESET])   prio_pick[BTN_RESET]   = 1'b1;
      else if (p[BTN_CONTAR])  prio_pick[BTN_CONTAR]  = 1'b1;
      else if (p[BTN_PAUSAR])  prio_pick[BTN_PAUSAR]  = 1'b1;
      else if (p[BTN_INICIAR]) prio_pick[BTN_INICIAR] = 1'b1;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control link between the stopwatch sequencer and the BCD counter/display datapath.
// Plain wires: the sequencer registers its outputs, the datapath registers its status flags.
interface stopwatch_ctrl_if;
   logic tick;
   logic cnt_clr;
   logic disp_hold;
   logic cnt_at_max;
   logic cnt_nonzero;

   modport master (output tick, output cnt_clr, output disp_hold,
                   input  cnt_at_max, input cnt_nonzero);
   modport slave  (input  tick, input cnt_clr, input disp_hold,
                   output cnt_at_max, output cnt_nonzero);
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One button: 2-FF synchronizer, stable-count debouncer, one-cycle press pulse on accepted 1->0.
// Latency 1 + DEBOUNCE_CYCLES clocks from first low sample to press; no backpressure.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         level      <= 1'b1;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != level) begin
            if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level      <= sync2;
               stable_cnt <= '0;
               press      <= ~sync2;
            end else begin
               stable_cnt <= stable_cnt + CW'(1);
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive the mode FSM, which gates a 10 Hz tick prescaler.
// State/cnt_clr/disp_hold update one clock after a press pulse; tick is registered; no backpressure.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV        = TICK_DIV_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ButtonIniciar,
   input  logic                    ButtonReset,
   input  logic                    ButtonContar,
   input  logic                    ButtonPausar,
   input  logic                    ButtonParar,
   stopwatch_ctrl_if.master        dp,
   output logic [2:0]              state
);

   localparam int PW = $clog2(TICK_DIV);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] press;
   logic [NUM_BTN-1:0] act;
   sw_state_e          state_q;
   sw_state_e          state_nxt;
   logic               clr_nxt;
   logic               clr_q;
   logic               hold_q;
   logic               tick_q;
   logic [PW-1:0]      presc;
   logic               counting;
   logic               counting_nxt;
   logic               wrap;

   assign btn_raw = {ButtonParar, ButtonPausar, ButtonContar, ButtonReset, ButtonIniciar};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .btn_n (btn_raw[i]),
         .press (press[i])
      );
   end

   assign act          = prio_pick(press);
   assign counting     = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign counting_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
   assign wrap         = (presc == PW'(TICK_DIV - 1));

   // Saturation only acts when no accepted press claims the cycle.
   always_comb begin
      state_nxt = state_q;
      clr_nxt   = 1'b0;
      unique case (state_q)
         ST_OFF: begin
            if (act[BTN_INICIAR]) state_nxt = ST_READY;
         end
         ST_READY: begin
            if (act[BTN_PARAR])                           state_nxt = ST_OFF;
            else if (act[BTN_RESET])                      clr_nxt   = 1'b1;
            else if (act[BTN_CONTAR])                     state_nxt = ST_RUN;
            else if (act[BTN_PAUSAR] && dp.cnt_nonzero)   state_nxt = ST_LAP;
         end
         ST_RUN, ST_LAP: begin
            if (act[BTN_PARAR]) begin
               state_nxt = ST_OFF;
            end else if (act[BTN_RESET]) begin
               clr_nxt   = 1'b1;
               state_nxt = ST_READY;
            end else if (state_q == ST_RUN && act[BTN_PAUSAR]) begin
               state_nxt = ST_LAP;
            end else if (state_q == ST_LAP && act[BTN_CONTAR]) begin
               state_nxt = ST_RUN;
            end else if (dp.cnt_at_max) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (act[BTN_PARAR]) begin
               state_nxt = ST_OFF;
            end else if (act[BTN_RESET]) begin
               clr_nxt   = 1'b1;
               state_nxt = ST_READY;
            end
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         clr_q   <= 1'b0;
         hold_q  <= 1'b0;
         tick_q  <= 1'b0;
         presc   <= '0;
      end else begin
         state_q <= state_nxt;
         clr_q   <= clr_nxt;
         hold_q  <= (state_nxt == ST_LAP);
         // Tick is withheld on the edge that leaves RUN/LAP so it never coincides with another state.
         tick_q  <= counting && wrap && counting_nxt;
         if (clr_nxt)       presc <= '0;
         else if (counting) presc <= wrap ? '0 : presc + PW'(1);
      end
   end

   assign dp.tick      = tick_q;
   assign dp.cnt_clr   = clr_q;
   assign dp.disp_hold = hold_q;
   assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic against a window/arithmetic model.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int TD = 4;
   localparam int DC = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [4:0] btn   = 5'b11111;
   logic [2:0] state;

   stopwatch_ctrl_if dpif ();

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ButtonIniciar (btn[BTN_INICIAR]),
      .ButtonReset   (btn[BTN_RESET]),
      .ButtonContar  (btn[BTN_CONTAR]),
      .ButtonPausar  (btn[BTN_PAUSAR]),
      .ButtonParar   (btn[BTN_PARAR]),
      .dp            (dpif),
      .state         (state)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit hist [NUM_BTN][DC+1];
   bit db     [NUM_BTN];
   bit mpress [NUM_BTN];
   int m_state;
   bit m_tick, m_clr, m_hold;
   int ncount;
   int prio_order [5] = '{BTN_PARAR, BTN_RESET, BTN_CONTAR, BTN_PAUSAR, BTN_INICIAR};
   int pick, ns;
   bit clr, run_old, allz, allo;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BTN; b++) begin
            db[b] = 1'b1;
            mpress[b] = 1'b0;
            for (int i = 0; i <= DC; i++) hist[b][i] = 1'b1;
         end
         m_state = 0; m_tick = 0; m_clr = 0; m_hold = 0; ncount = 0;
      end else begin
         pick = -1;
         for (int k = 0; k < 5; k++)
            if (pick < 0 && mpress[prio_order[k]]) pick = prio_order[k];
         run_old = (m_state == 2) || (m_state == 3);
         ns  = m_state;
         clr = 1'b0;
         case (m_state)
            0: if (pick == BTN_INICIAR) ns = 1;
            1: begin
               if (pick == BTN_PARAR) ns = 0;
               else if (pick == BTN_RESET) clr = 1'b1;
               else if (pick == BTN_CONTAR) ns = 2;
               else if (pick == BTN_PAUSAR && dpif.cnt_nonzero) ns = 3;
            end
            2: begin
               if (pick == BTN_PARAR) ns = 0;
               else if (pick == BTN_RESET) begin clr = 1'b1; ns = 1; end
               else if (pick == BTN_PAUSAR) ns = 3;
               else if (dpif.cnt_at_max) ns = 4;
            end
            3: begin
               if (pick == BTN_PARAR) ns = 0;
               else if (pick == BTN_RESET) begin clr = 1'b1; ns = 1; end
               else if (pick == BTN_CONTAR) ns = 2;
               else if (dpif.cnt_at_max) ns = 4;
            end
            default: begin
               if (pick == BTN_PARAR) ns = 0;
               else if (pick == BTN_RESET) begin clr = 1'b1; ns = 1; end
            end
         endcase
         if (clr) begin
            ncount = 0;
            m_tick = 1'b0;
         end else if (run_old) begin
            ncount++;
            m_tick = (ncount % TD == 0) && (ns == 2 || ns == 3);
         end else begin
            m_tick = 1'b0;
         end
         m_clr   = clr;
         m_hold  = (ns == 3);
         m_state = ns;
         // A level is accepted once the last DC synchronized samples all show the new value.
         for (int b = 0; b < NUM_BTN; b++) begin
            allz = 1'b1; allo = 1'b1;
            for (int i = 1; i <= DC; i++) begin
               if (hist[b][i]) allz = 1'b0; else allo = 1'b0;
            end
            mpress[b] = 1'b0;
            if (db[b] && allz) begin db[b] = 1'b0; mpress[b] = 1'b1; end
            else if (!db[b] && allo) db[b] = 1'b1;
            for (int i = DC; i >= 1; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = btn[b];
         end
      end
   end

   int tick_cnt = 0;
   int clr_cnt  = 0;
   int hold_cnt = 0;

   always @(negedge clk) begin
      chk("mon_state", state, m_state);
      chk("mon_tick", dpif.tick, m_tick);
      chk("mon_clr", dpif.cnt_clr, m_clr);
      chk("mon_hold", dpif.disp_hold, m_hold);
      if (dpif.tick)      tick_cnt++;
      if (dpif.cnt_clr)   clr_cnt++;
      if (dpif.disp_hold) hold_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic press(input logic [4:0] mask, input int hold);
      btn = ~mask;
      repeat (hold) @(posedge clk);
      #1 btn = 5'b11111;
      repeat (DC + 5) @(posedge clk);
      #1;
   endtask

   int  t0, c0, h0, n, first, pcnt, hold_len;
   bit  found;
   logic [4:0] mask;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      dpif.cnt_at_max  = 1'b0;
      dpif.cnt_nonzero = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", state, ST_OFF);
      chk("rst_tick", dpif.tick, 0);
      chk("rst_clr", dpif.cnt_clr, 0);
      chk("rst_hold", dpif.disp_hold, 0);
      rst_n = 1'b1;

      // 1: Contar held in OFF does nothing
      t0 = tick_cnt; c0 = clr_cnt; h0 = hold_cnt;
      press(5'(1 << BTN_CONTAR), 10);
      chk("s1_state", state, ST_OFF);
      chk("s1_ticks", tick_cnt - t0, 0);
      chk("s1_clr", clr_cnt - c0, 0);
      chk("s1_hold", hold_cnt - h0, 0);

      // 2: Iniciar then Contar, tick cadence from zeroed prescaler
      press(5'(1 << BTN_INICIAR), 6);
      chk("s2_ready", state, ST_READY);
      btn[BTN_CONTAR] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (state == ST_RUN) found = 1'b1;
      end
      chk("s2_run_entry", found, 1);
      n = 0; first = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (dpif.tick) begin
            n++;
            if (first < 0) first = k;
         end
      end
      chk("s2_tick_count", n, 5);
      chk("s2_first_tick", first, 4);
      @(posedge clk);
      #1 btn = 5'b11111;
      repeat (DC + 5) @(posedge clk);
      #1;

      // 3: Pausar glitch rejected, then LAP with ticks continuing, then back to RUN
      press(5'(1 << BTN_PAUSAR), 2);
      chk("s3_glitch_state", state, ST_RUN);
      press(5'(1 << BTN_PAUSAR), 5);
      chk("s3_lap_state", state, ST_LAP);
      chk("s3_lap_hold", dpif.disp_hold, 1);
      t0 = tick_cnt;
      repeat (8) @(posedge clk);
      #1;
      chk("s3_lap_ticks", tick_cnt - t0, 2);
      press(5'(1 << BTN_CONTAR), 6);
      chk("s3_resume_state", state, ST_RUN);
      chk("s3_resume_hold", dpif.disp_hold, 0);

      // 4: Parar beats Reset on the same edge
      c0 = clr_cnt;
      press(5'((1 << BTN_PARAR) | (1 << BTN_RESET)), 6);
      chk("s4_state", state, ST_OFF);
      chk("s4_clr", clr_cnt - c0, 0);

      // 5: READY Pausar on zero ignored; LAP -> DONE on saturation; Reset clears
      press(5'(1 << BTN_INICIAR), 6);
      chk("s5_ready", state, ST_READY);
      press(5'(1 << BTN_PAUSAR), 6);
      chk("s5_pause_zero", state, ST_READY);
      dpif.cnt_nonzero = 1'b1;
      press(5'(1 << BTN_CONTAR), 6);
      chk("s5_run", state, ST_RUN);
      press(5'(1 << BTN_PAUSAR), 6);
      chk("s5_lap", state, ST_LAP);
      dpif.cnt_at_max = 1'b1;
      @(posedge clk);
      #1;
      chk("s5_done", state, ST_DONE);
      chk("s5_done_hold", dpif.disp_hold, 0);
      t0 = tick_cnt;
      repeat (12) @(posedge clk);
      #1;
      chk("s5_done_ticks", tick_cnt - t0, 0);
      c0 = clr_cnt;
      press(5'(1 << BTN_RESET), 6);
      chk("s5_reset_clr", clr_cnt - c0, 1);
      chk("s5_reset_state", state, ST_READY);
      dpif.cnt_at_max = 1'b0;

      // 6: async reset mid-RUN with Pausar held
      press(5'(1 << BTN_CONTAR), 6);
      chk("s6_run", state, ST_RUN);
      btn[BTN_PAUSAR] = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("s6_rst_state", state, ST_OFF);
      chk("s6_rst_tick", dpif.tick, 0);
      chk("s6_rst_clr", dpif.cnt_clr, 0);
      chk("s6_rst_hold", dpif.disp_hold, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      pcnt = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (dut.press[BTN_PAUSAR]) pcnt++;
      end
      chk("s6_press_count", pcnt, 1);
      chk("s6_state", state, ST_OFF);
      btn = 5'b11111;
      repeat (DC + 5) @(posedge clk);
      #1;

      // random traffic, checked cycle by cycle against the model
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 9) == 0) mask = 5'($urandom_range(0, 31));
         else mask = 5'(1 << $urandom_range(0, 4));
         hold_len = $urandom_range(1, 7);
         dpif.cnt_at_max  = ($urandom_range(0, 7) == 0);
         dpif.cnt_nonzero = 1'($urandom_range(0, 1));
         btn = ~mask;
         repeat (hold_len) @(posedge clk);
         #1 btn = 5'b11111;
         repeat ($urandom_range(0, 8)) @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the 0.1 s-resolution BCD stopwatch. It debounces the five active-low push-buttons and runs the stopwatch mode FSM. It drives the BCD counter/display datapath with a 10 Hz count-enable tick, a counter-clear pulse and a display-hold level. The BCD digit registers and 7-segment decode remain in the datapath; this block only tells them when to count, clear or freeze.

## Interface
- `TICK_DIV`, 5_000_000: clk cycles per 0.1 s tick (50 MHz board clock); must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronized samples needed to accept a level change (20 ms); must be ≥ 1.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ButtonIniciar` in 1: raw start button, active-low, asynchronous to `clk`.
- `ButtonReset` in 1: raw reset button, active-low, asynchronous.
- `ButtonContar` in 1: raw count/resume button, active-low, asynchronous.
- `ButtonPausar` in 1: raw pause/lap button, active-low, asynchronous.
- `ButtonParar` in 1: raw stop button, active-low, asynchronous.
- `cnt_at_max` in 1: datapath reads 999.9.
- `cnt_nonzero` in 1: datapath reads a value other than 000.0.
- `tick` out 1: one-cycle count enable, asserted only in RUN or LAP.
- `cnt_clr` out 1: one-cycle synchronous clear request to the digit registers.
- `disp_hold` out 1: freeze displayed value while counting continues.
- `state` out 3: current FSM state code, for debug and LEDs.

## Operation
- Button path, per button:
  - 2-FF synchronizer.
  - Debouncer: the stable counter increments while the synchronized level differs from the debounced level, and resets when they agree. On the DEBOUNCE_CYCLES-th consecutive mismatch, the debounced level updates.
  - A `press` pulse is registered on the same edge that the debounced level goes 1→0. Exactly one pulse per accepted press; release generates nothing.
- FSM states and codes:
  - OFF=0: idle; reset state.
  - READY=1: armed, not counting.
  - RUN=2: counting, display live.
  - LAP=3: counting, display frozen.
  - DONE=4: counter saturated at 999.9.
- Same-cycle press priority: Parar > Reset > Contar > Pausar > Iniciar. Only the highest-priority press acts; the others are dropped.
- Transitions:
  - OFF: Iniciar → READY with no clear (the held value is kept). All other presses are ignored.
  - READY: Contar → RUN. Pausar → LAP if `cnt_nonzero`, otherwise ignored. Reset → pulse `cnt_clr`, stay READY. Parar → OFF.
  - RUN: Pausar → LAP. Reset → `cnt_clr`, READY. Parar → OFF. `cnt_at_max` → DONE.
  - LAP: Contar → RUN. Pausar is ignored. Reset → `cnt_clr`, READY. Parar → OFF. `cnt_at_max` → DONE.
  - DONE: Reset → `cnt_clr`, READY. Parar → OFF. Other presses are ignored.
- `cnt_at_max` is checked after button presses: any accepted press in the same cycle wins.
- Prescaler: 0..TICK_DIV-1.
  - Increments only in RUN/LAP and holds in all other states.
  - `tick`=1 in the cycle after the prescaler equals TICK_DIV-1, which wraps it to 0.
  - Prescaler is zeroed on every `cnt_clr`.
- `disp_hold` = 1 exactly while the state is LAP.

## Timing
- Reset values:
  - `state`=OFF, `tick`=0, `cnt_clr`=0, `disp_hold`=0.
  - Prescaler 0; all debounced levels 1 (released); all stable counters 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Press latency: with raw low first sampled at edge N and held, `press` is high after edge N+1+DEBOUNCE_CYCLES. The FSM reacts and `state`/`cnt_clr`/`disp_hold` update after edge N+2+DEBOUNCE_CYCLES.
- Tick timing: the first `tick` occurs TICK_DIV cycles after entering RUN from a zeroed prescaler. Ticks then repeat exactly every TICK_DIV cycles, continuous across RUN↔LAP.
- `cnt_clr` is high for one cycle, coincident with the state update. The datapath clears on the following edge.
- No `tick` is asserted in DONE. Because TICK_DIV ≥ 2, the datapath's `cnt_at_max` is seen before any further tick could occur.
- Asynchronous `rst_n` mid-operation returns everything to reset values immediately. A button held through reset deassertion is debounced afresh and produces one press.

## Structure
- Package `stopwatch_pkg`: state enum/codes (OFF..DONE), default TICK_DIV and DEBOUNCE_CYCLES constants.
- Sub-module `btn_debounce` (synchronizer + debouncer + press pulse; parameter DEBOUNCE_CYCLES), instantiated five times.
- The FSM and prescaler live in the top module.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_CYCLES=3.
1. Reset, then Contar held for 10 cycles → state stays OFF; `tick`, `cnt_clr` and `disp_hold` stay 0.
2. Iniciar, then Contar, then hold for 20 cycles → state 1 then 2. `tick` pulses 4 cycles after RUN entry, then every 4 cycles (5 pulses).
3. Pausar glitch low for 2 cycles while in RUN → no state change. Then held low for 5 cycles → LAP, `disp_hold`=1, ticks uninterrupted. Then Contar → RUN, `disp_hold`=0.
4. In RUN, Parar and Reset pressed on the same edge → state OFF; `cnt_clr` never asserted.
5. In LAP, `cnt_at_max`=1 → DONE, `disp_hold`=0, no `tick` for 12 cycles. Then Reset → one-cycle `cnt_clr`, state READY.
6. `rst_n` pulsed low mid-RUN while Pausar is held → all outputs 0 and state OFF during reset; after release, exactly one Pausar press is accepted (ignored in OFF).
